// File: rtl/pokey_ctrl_responder.sv
// pokey_ctrl_responder: board-side keyboard and paddle emulator for POKEY.
// Define POKEY_CTRL_DEBOUNCE_EN to debounce the held key before commit.

module pokey_pot_ch #(
  parameter int POT_MAX = 228
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       line_tick,
  input  logic       pot_rel,
  input  logic [7:0] pot_val,
  output logic       scan
);

  localparam logic [7:0] PMAX = 8'(POT_MAX);

  typedef enum logic [1:0] {
    DUMP,
    COUNT,
    DONE
  } pot_st_t;

  pot_st_t    st, st_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] tgt, tgt_n;
  logic [7:0] lim;

  assign lim = (pot_val > PMAX) ? PMAX : pot_val;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      st  <= DUMP;
      cnt <= '0;
      tgt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      tgt <= tgt_n;
    end
  end

  // A dropped release always wins, even over a tick on the same edge.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    tgt_n = tgt;
    if (!pot_rel) begin
      st_n  = DUMP;
      cnt_n = '0;
    end else begin
      unique case (st)
        DUMP: begin
          cnt_n = '0;
          tgt_n = lim;
          st_n  = (lim == 8'd0) ? DONE : COUNT;
        end
        COUNT: begin
          if (line_tick) begin
            cnt_n = cnt + 8'd1;
            if (cnt + 8'd1 == tgt) st_n = DONE;
          end
        end
        DONE:    st_n = DONE;
        default: st_n = DUMP;
      endcase
    end
  end

  assign scan = (st == DONE);

endmodule

module pokey_ctrl_responder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int POT_MAX         = 228
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] key_scan_L,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       kr1_L,
  output logic       key_stable,
  input  logic       line_tick,
  input  logic       pot_rel_0,
  input  logic       pot_rel_1,
  input  logic [7:0] pot_val0,
  input  logic [7:0] pot_val1,
  output logic [1:0] pot_scan_2
);

  logic [4:0] key_in;
  logic [4:0] key_q;

  assign key_in = {key_valid, key_code};

`ifdef POKEY_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [4:0]    shadow;
  logic [CW-1:0] db_cnt;

  // Counter saturates once committed so it never wraps into a recommit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shadow <= '0;
      db_cnt <= '0;
      key_q  <= '0;
    end else if (key_in != shadow) begin
      shadow <= key_in;
      db_cnt <= '0;
    end else if (db_cnt != CMAX) begin
      db_cnt <= db_cnt + 1'b1;
      if (db_cnt == CMAX - 1'b1) key_q <= key_in;
    end
  end
`else
  logic unused_deb;
  assign unused_deb = |DEBOUNCE_CYCLES;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) key_q <= '0;
    else          key_q <= key_in;
  end
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) kr1_L <= 1'b1;
    else          kr1_L <= ~(key_q[4] && (~key_scan_L == key_q[3:0]));
  end

  assign key_stable = key_q[4];

  pokey_pot_ch #(.POT_MAX(POT_MAX)) u_pot0 (
    .clk      (clk),
    .n_reset  (n_reset),
    .line_tick(line_tick),
    .pot_rel  (pot_rel_0),
    .pot_val  (pot_val0),
    .scan     (pot_scan_2[0])
  );

  pokey_pot_ch #(.POT_MAX(POT_MAX)) u_pot1 (
    .clk      (clk),
    .n_reset  (n_reset),
    .line_tick(line_tick),
    .pot_rel  (pot_rel_1),
    .pot_val  (pot_val1),
    .scan     (pot_scan_2[1])
  );

endmodule
